// File: rtl/rom_bank_loader_if.sv
// rom_bank_loader_if: CPU access and streaming-loader signals of the banked ROM.
interface rom_bank_loader_if #(
    parameter int BANKS   = 4,
    parameter int BANK_KB = 16,
    parameter int DW      = 8
);
    localparam int BW = $clog2(BANKS);
    localparam int AW = $clog2(BANK_KB * 1024);
    logic [BW-1:0] bank;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          w;
    logic [DW-1:0] q;
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_busy;
    logic          ld_done;
    logic [7:0]    ld_sum;
    modport master (
        output bank, a, d, w, ld_start, ld_valid, ld_data,
        input  q, ld_ready, ld_busy, ld_done, ld_sum
    );
    modport slave (
        input  bank, a, d, w, ld_start, ld_valid, ld_data,
        output q, ld_ready, ld_busy, ld_done, ld_sum
    );
endinterface

// File: rtl/rom_bank_loader.sv
// rom_bank_loader: banked ROM/RAM with 1-cycle CPU reads and a streaming full-array loader.
// Define ROM_CHECKSUM_EN to build the modulo-256 load checksum on ld_sum.
module rom_bank_loader #(
    parameter int BANKS    = 4,
    parameter int BANK_KB  = 16,
    parameter int DW       = 8,
    parameter bit WRITABLE = 1
) (
    input logic             clock,
    input logic             reset,
    rom_bank_loader_if.slave bus
);
    localparam int BW    = $clog2(BANKS);
    localparam int AW    = $clog2(BANK_KB * 1024);
    localparam int DEPTH = BANKS * BANK_KB * 1024;
    localparam int CW    = BW + AW;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [CW-1:0] counter;
    logic [CW-1:0] addr;
    logic          beat;
    logic          start;
    logic          cpu_wr;
    assign addr   = {bus.bank, bus.a};
    assign beat   = reset && state == LOAD && bus.ld_valid && bus.ld_ready;
    assign start  = state != LOAD && bus.ld_start;
    // ld_start outranks the CPU, so a start cycle never writes memory
    assign cpu_wr = WRITABLE && reset && state != LOAD && !start && bus.w;
    always_ff @(posedge clock) begin
        if (beat)
            mem[counter] <= bus.ld_data;
        else if (cpu_wr)
            mem[addr] <= bus.d;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= '0;
            bus.q        <= '0;
            bus.ld_ready <= 1'b0;
            bus.ld_busy  <= 1'b0;
            bus.ld_done  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    bus.q <= '1;
                    if (beat) begin
                        counter <= counter + 1'b1;
                        if (counter == LAST) begin
                            state        <= DONE;
                            bus.ld_ready <= 1'b0;
                            bus.ld_busy  <= 1'b0;
                            bus.ld_done  <= 1'b1;
                        end
                    end
                end
                IDLE, DONE: begin
                    if (start) begin
                        state        <= LOAD;
                        counter      <= '0;
                        bus.q        <= '1;
                        bus.ld_ready <= 1'b1;
                        bus.ld_busy  <= 1'b1;
                        bus.ld_done  <= 1'b0;
                    end else begin
                        bus.q <= cpu_wr ? bus.d : mem[addr];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ROM_CHECKSUM_EN
    always_ff @(posedge clock) begin
        if (!reset || start)
            bus.ld_sum <= 8'h00;
        else if (beat)
            bus.ld_sum <= bus.ld_sum + bus.ld_data[7:0];
    end
`else
    assign bus.ld_sum = 8'h00;
`endif
endmodule
